// File: rtl/instruction_control_fsm_if.sv
// Control bundle between the instruction control FSM and the 8-bit datapath:
// the opcode and status inputs, and the per-cycle stage and accumulator controls.
interface instruction_control_fsm_if;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       Enter;

    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [3:0] State;

    // The FSM side issues the controls.
    modport master (
        input  IR, Aeq0, Apos, Enter,
        output IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt, State
    );

    // The datapath side supplies the opcode and accumulator status.
    modport slave (
        output IR, Aeq0, Apos, Enter,
        input  IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt, State
    );
endinterface

// File: rtl/instruction_control_fsm.sv
// Fetch/decode/execute sequencer for the eight-instruction ISA of the 8-bit datapath,
// including the Enter-key handshake for INPUT and the terminal HALT state.
module instruction_control_fsm (
    input  logic                         Clock,
    input  logic                         Reset,
    instruction_control_fsm_if.master    bus
);
    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_INLOAD = 4'd8,
        S_INREL  = 4'd9,
        S_JZ     = 4'd10,
        S_JPOS   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_EXT = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

    // Kept as a plain 4-bit vector so the illegal codes 13-15 are representable
    // and recovered from, rather than being outside the enum's value set.
    logic [3:0] state;
    state_t     next_state;

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value; blocking here would create order-dependent races.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= S_START;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output and next_state gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state  = S_START;
        bus.IRload  = 1'b0;
        bus.PCload  = 1'b0;
        bus.JMPmux  = 1'b0;
        bus.Meminst = 1'b0;
        bus.MemWr   = 1'b0;
        bus.Asel    = ASEL_ALU;
        bus.Aload   = 1'b0;
        bus.Sub     = 1'b0;
        bus.Halt    = 1'b0;

        case (state)
            S_START: next_state = S_FETCH;

            S_FETCH: begin
                bus.IRload = 1'b1;
                bus.PCload = 1'b1;
                next_state = S_DECODE;
            end

            S_DECODE: begin
                bus.Meminst = 1'b1;
                case (bus.IR)
                    3'b000:  next_state = S_LOAD;
                    3'b001:  next_state = S_STORE;
                    3'b010:  next_state = S_ADD;
                    3'b011:  next_state = S_SUB;
                    3'b100:  next_state = S_INPUT;
                    3'b101:  next_state = S_JZ;
                    3'b110:  next_state = S_JPOS;
                    default: next_state = S_HALT;
                endcase
            end

            S_LOAD: begin
                bus.Meminst = 1'b1;
                bus.Asel    = ASEL_RAM;
                bus.Aload   = 1'b1;
                next_state  = S_FETCH;
            end

            S_STORE: begin
                bus.Meminst = 1'b1;
                bus.MemWr   = 1'b1;
                next_state  = S_FETCH;
            end

            S_ADD: begin
                bus.Meminst = 1'b1;
                bus.Aload   = 1'b1;
                next_state  = S_FETCH;
            end

            S_SUB: begin
                bus.Meminst = 1'b1;
                bus.Sub     = 1'b1;
                bus.Aload   = 1'b1;
                next_state  = S_FETCH;
            end

            S_INPUT: next_state = bus.Enter ? S_INLOAD : S_INPUT;

            S_INLOAD: begin
                bus.Asel   = ASEL_EXT;
                bus.Aload  = 1'b1;
                next_state = S_INREL;
            end

            // Waiting for key release guarantees one accumulator load per press.
            S_INREL: next_state = bus.Enter ? S_INREL : S_FETCH;

            // The only Mealy outputs: the PC register takes the jump on the edge
            // leaving this state, so the status flag is passed straight through.
            S_JZ: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Aeq0;
                next_state = S_FETCH;
            end

            S_JPOS: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Apos;
                next_state = S_FETCH;
            end

            S_HALT: begin
                bus.Halt   = 1'b1;
                next_state = S_HALT;
            end

            default: next_state = S_START;
        endcase
    end

    assign bus.State = state;
endmodule

// File: tb/tb_instruction_control_fsm.sv
// Scoreboard bench for instruction_control_fsm: each stimulus step pushes the
// expected post-edge state and controls, popped and compared on the falling edge.
module tb_instruction_control_fsm;
    logic clk;
    logic rst_n;

    instruction_control_fsm_if bus ();

    instruction_control_fsm dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       irload;
        logic       pcload;
        logic       jmpmux;
        logic       meminst;
        logic       memwr;
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       halt;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [2:0] ir;
        logic       aeq0;
        logic       apos;
        logic       enter;
        logic [3:0] st;
    } step_t;

    obs_t  sb[$];
    step_t steps[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference outputs for each state code, straight from the control table.
    function automatic obs_t expect_for(input logic [3:0] st, input logic aeq0, input logic apos);
        obs_t o;
        o       = '0;
        o.state = st;
        case (st)
            4'd1:  begin o.irload = 1'b1; o.pcload = 1'b1; end
            4'd2:  o.meminst = 1'b1;
            4'd3:  begin o.meminst = 1'b1; o.asel = 2'b10; o.aload = 1'b1; end
            4'd4:  begin o.meminst = 1'b1; o.memwr = 1'b1; end
            4'd5:  begin o.meminst = 1'b1; o.aload = 1'b1; end
            4'd6:  begin o.meminst = 1'b1; o.aload = 1'b1; o.sub = 1'b1; end
            4'd8:  begin o.asel = 2'b01; o.aload = 1'b1; end
            4'd10: begin o.jmpmux = 1'b1; o.pcload = aeq0; end
            4'd11: begin o.jmpmux = 1'b1; o.pcload = apos; end
            4'd12: o.halt = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state   = bus.State;
        o.irload  = bus.IRload;
        o.pcload  = bus.PCload;
        o.jmpmux  = bus.JMPmux;
        o.meminst = bus.Meminst;
        o.memwr   = bus.MemWr;
        o.asel    = bus.Asel;
        o.aload   = bus.Aload;
        o.sub     = bus.Sub;
        o.halt    = bus.Halt;
        return o;
    endfunction

    function automatic step_t mk(input logic rst, input logic [2:0] ir, input logic aeq0,
                                 input logic apos, input logic enter, input logic [3:0] st);
        step_t s;
        s.rst = rst; s.ir = ir; s.aeq0 = aeq0; s.apos = apos; s.enter = enter; s.st = st;
        return s;
    endfunction

    // Called just after a falling edge: apply inputs, record what the next edge must yield.
    task automatic drive(input step_t s);
        rst_n     = s.rst;
        bus.IR    = s.ir;
        bus.Aeq0  = s.aeq0;
        bus.Apos  = s.apos;
        bus.Enter = s.enter;
        sb.push_back(expect_for(s.st, s.aeq0, s.apos));
        @(posedge clk);
    endtask

    task automatic test_reset();
        obs_t exp_o, obs_o;
        steps = {};
        steps.push_back(mk(0, 3'b100, 0, 0, 0, 4'd0));
        steps.push_back(mk(0, 3'b100, 0, 0, 0, 4'd0));
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd1));
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd7));
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd8));
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd9));
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd9));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL reset_pre step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end

        // Reset goes low while parked in INREL: outputs still show INREL before the edge.
        rst_n = 1'b0;
        #1;
        obs_o = sample();
        n_tests++;
        if (obs_o !== expect_for(4'd9, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_before_edge: got state=%0d ctrl=%b, expected state=9 ctrl=0",
                     obs_o.state, obs_o[10:0]);
        end

        steps = {};
        for (int k = 0; k < 3; k++) steps.push_back(mk(0, 3'b100, 1, 1, 1, 4'd0));
        steps.push_back(mk(1, 3'b000, 0, 0, 0, 4'd1));
        steps.push_back(mk(1, 3'b000, 0, 0, 0, 4'd2));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL reset_hold step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end
    endtask

    // Entered with the FSM in DECODE and IR to be sampled as LOAD.
    task automatic test_load_add();
        obs_t exp_o, obs_o;
        steps = {};
        steps.push_back(mk(1, 3'b000, 0, 0, 0, 4'd3));
        steps.push_back(mk(1, 3'b010, 0, 0, 0, 4'd1));
        steps.push_back(mk(1, 3'b010, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b010, 1, 1, 0, 4'd5));
        steps.push_back(mk(1, 3'b010, 0, 0, 0, 4'd1));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL load_add step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end
    endtask

    task automatic test_store_sub();
        obs_t exp_o, obs_o;
        int   memwr_cycles;
        memwr_cycles = 0;
        steps = {};
        steps.push_back(mk(1, 3'b001, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b001, 0, 0, 0, 4'd4));
        steps.push_back(mk(1, 3'b011, 0, 0, 0, 4'd1));
        steps.push_back(mk(1, 3'b011, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b011, 0, 0, 0, 4'd6));
        steps.push_back(mk(1, 3'b011, 0, 0, 0, 4'd1));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            if (obs_o.memwr === 1'b1) memwr_cycles++;
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL store_sub step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end
        n_tests++;
        if (memwr_cycles !== 1) begin
            n_fail++;
            $display("FAIL store_memwr_count: got %0d cycles, expected 1", memwr_cycles);
        end
    endtask

    task automatic test_jumps();
        obs_t exp_o, obs_o;
        steps = {};
        steps.push_back(mk(1, 3'b101, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b101, 1, 0, 0, 4'd10));
        steps.push_back(mk(1, 3'b101, 1, 1, 0, 4'd1));
        steps.push_back(mk(1, 3'b101, 1, 1, 0, 4'd2));
        steps.push_back(mk(1, 3'b101, 0, 1, 0, 4'd10));
        steps.push_back(mk(1, 3'b110, 1, 1, 0, 4'd1));
        steps.push_back(mk(1, 3'b110, 1, 1, 0, 4'd2));
        steps.push_back(mk(1, 3'b110, 1, 0, 0, 4'd11));
        steps.push_back(mk(1, 3'b110, 0, 0, 0, 4'd1));
        steps.push_back(mk(1, 3'b110, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b110, 0, 1, 0, 4'd11));
        steps.push_back(mk(1, 3'b110, 0, 0, 0, 4'd1));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL jumps step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end
    endtask

    task automatic test_input();
        obs_t exp_o, obs_o;
        int   loads;
        loads = 0;
        steps = {};
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd2));
        for (int k = 0; k < 5; k++) steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd7));
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd8));
        for (int k = 0; k < 3; k++) steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd9));
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd1));
        // Enter already held when INPUT is entered: no extra wait cycle.
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd2));
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd7));
        steps.push_back(mk(1, 3'b100, 0, 0, 1, 4'd8));
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd9));
        steps.push_back(mk(1, 3'b100, 0, 0, 0, 4'd1));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            if (obs_o.aload === 1'b1) loads++;
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL input step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end
        n_tests++;
        if (loads !== 2) begin
            n_fail++;
            $display("FAIL input_load_count: got %0d loads, expected 2", loads);
        end
    endtask

    task automatic test_halt_illegal();
        obs_t exp_o, obs_o;
        steps = {};
        steps.push_back(mk(1, 3'b111, 0, 0, 0, 4'd2));
        steps.push_back(mk(1, 3'b111, 0, 0, 0, 4'd12));
        for (int k = 0; k < 20; k++) begin
            steps.push_back(mk(1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd12));
        end
        steps.push_back(mk(0, 3'b111, 0, 0, 0, 4'd0));
        steps.push_back(mk(1, 3'b000, 0, 0, 0, 4'd1));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL halt step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end

        // Corrupt the state register to an illegal code: all outputs 0, then back to START.
        dut.state = 4'd14;
        #1;
        obs_o = sample();
        n_tests++;
        if (obs_o !== expect_for(4'd14, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL illegal_outputs: got state=%0d ctrl=%b, expected state=14 ctrl=0",
                     obs_o.state, obs_o[10:0]);
        end
        steps = {};
        steps.push_back(mk(1, 3'b000, 1, 1, 1, 4'd0));
        steps.push_back(mk(1, 3'b000, 1, 1, 1, 4'd1));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge clk);
            exp_o = sb.pop_front();
            obs_o = sample();
            n_tests++;
            if (obs_o !== exp_o) begin
                n_fail++;
                $display("FAIL illegal step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, obs_o.state, obs_o[10:0], exp_o.state, exp_o[10:0]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.IR    = 3'b000;
        bus.Aeq0  = 1'b0;
        bus.Apos  = 1'b0;
        bus.Enter = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_add();
        test_store_sub();
        test_jumps();
        test_input();
        test_halt_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
